// File: rtl/sq_wave_pkg.sv
// rtl/sq_wave_pkg.sv - shared square-wave generator/meter definitions
// Purpose: FSM state encoding for the meter and width defaults shared with the
//          square-wave generator (its on/off length width sets the meter width).
// Ports:   none (package)
package sq_wave_pkg;

  // Generator on/off length register width; meter counters default to match.
  localparam int GEN_ONOFF_W     = 8;
  localparam int DEF_CNT_W       = GEN_ONOFF_W;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_TIMEOUT     = 200;
  localparam int IDLE_CNT_W      = 16;

  // LOW0 is the first low phase after IDLE: the preceding high is unknown, so
  // the period that it closes is never published.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW0 = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } meter_state_t;

endpackage

// File: rtl/square_wave_meter_if.sv
// rtl/square_wave_meter_if.sv - control and result bundle of the square-wave meter
// Purpose: groups the meter's enable/input and published measurement signals.
// Signals: en, sig_in (to meter); high_len, low_len, period, meas_valid,
//          meas_sat, stuck, stuck_level (from meter).
// Modports: master = stimulus/consumer side, slave = meter side.
interface square_wave_meter_if
  import sq_wave_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);
  logic             en;
  logic             sig_in;
  logic [CNT_W-1:0] high_len;
  logic [CNT_W-1:0] low_len;
  logic [CNT_W:0]   period;
  logic             meas_valid;
  logic             meas_sat;
  logic             stuck;
  logic             stuck_level;

  modport master (
    output en, sig_in,
    input  high_len, low_len, period, meas_valid, meas_sat, stuck, stuck_level
  );

  modport slave (
    input  en, sig_in,
    output high_len, low_len, period, meas_valid, meas_sat, stuck, stuck_level
  );
endinterface

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - input synchronizer with edge detection
// Purpose: brings an asynchronous level into the clk domain and flags its edges.
// Ports:   clk, rst (async, active-high); sig_in (async level);
//          s (synchronized level), rise, fall (single-cycle, combinational
//          from s and its one-cycle-delayed copy).
module sync_edge_det
  import sq_wave_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic s,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      prev   <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~prev;
  assign fall = ~s & prev;
endmodule

// File: rtl/square_wave_meter.sv
// rtl/square_wave_meter.sv - square-wave high/low/period meter with stuck detect
// Purpose: measures high time, low time and period of sig_in in clk cycles and
//          publishes one result per full period; flags an edge-less input.
// Ports:   clk, rst (async, active-high);
//          bus (slave): en, sig_in in; high_len, low_len, period, meas_valid,
//          meas_sat, stuck, stuck_level out.
module square_wave_meter
  import sq_wave_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input logic                clk,
  input logic                rst,
  square_wave_meter_if.slave bus
);
  localparam logic [CNT_W-1:0]      CNT_MAX    = '1;
  localparam logic [IDLE_CNT_W-1:0] TIMEOUT_M1 = IDLE_CNT_W'(TIMEOUT - 1);

  logic s, rise, fall, any_edge;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst    (rst),
    .sig_in (bus.sig_in),
    .s      (s),
    .rise   (rise),
    .fall   (fall)
  );

  meter_state_t          state, state_nxt;
  logic [CNT_W-1:0]      hcnt, lcnt;
  logic                  hsat, lsat;
  logic [IDLE_CNT_W-1:0] idle_cnt;
  logic                  timeout_hit;
  logic                  load_h, load_l, inc_h, inc_l, publish, clr_cnt;

  logic [CNT_W-1:0] high_len_q, low_len_q;
  logic [CNT_W:0]   period_q;
  logic             meas_valid_q, meas_sat_q, stuck_q, stuck_level_q;

  assign any_edge = rise | fall;
  // An edge in the same cycle as the limit resets the idle count instead.
  assign timeout_hit = bus.en && !any_edge && (idle_cnt == TIMEOUT_M1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_h    = 1'b0;
    load_l    = 1'b0;
    inc_h     = 1'b0;
    inc_l     = 1'b0;
    publish   = 1'b0;
    clr_cnt   = 1'b0;
    if (!bus.en || timeout_hit) begin
      state_nxt = ST_IDLE;
      clr_cnt   = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fall) begin
            state_nxt = ST_LOW0;
            load_l    = 1'b1;
          end
        end
        ST_LOW0: begin
          if (rise) begin
            state_nxt = ST_HIGH;
            load_h    = 1'b1;
          end else begin
            inc_l = 1'b1;
          end
        end
        ST_HIGH: begin
          if (fall) begin
            state_nxt = ST_LOW;
            load_l    = 1'b1;
          end else begin
            inc_h = 1'b1;
          end
        end
        ST_LOW: begin
          if (rise) begin
            state_nxt = ST_HIGH;
            load_h    = 1'b1;
            publish   = 1'b1;
          end else begin
            inc_l = 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Length counters: a load counts the edge cycle itself as the first cycle.
  // At the ceiling the count freezes and the sat flag records the lost cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt <= '0;
      lcnt <= '0;
      hsat <= 1'b0;
      lsat <= 1'b0;
    end else if (clr_cnt) begin
      hcnt <= '0;
      lcnt <= '0;
      hsat <= 1'b0;
      lsat <= 1'b0;
    end else begin
      if (load_h) begin
        hcnt <= CNT_W'(1);
        hsat <= 1'b0;
      end else if (inc_h) begin
        if (hcnt == CNT_MAX) hsat <= 1'b1;
        else                 hcnt <= hcnt + CNT_W'(1);
      end
      if (load_l) begin
        lcnt <= CNT_W'(1);
        lsat <= 1'b0;
      end else if (inc_l) begin
        if (lcnt == CNT_MAX) lsat <= 1'b1;
        else                 lcnt <= lcnt + CNT_W'(1);
      end
    end
  end

  // Idle counter and stuck flag. The counter saturates so the timeout fires
  // only once per edge-less stretch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt      <= '0;
      stuck_q       <= 1'b0;
      stuck_level_q <= 1'b0;
    end else if (!bus.en || any_edge) begin
      idle_cnt <= '0;
      stuck_q  <= 1'b0;
    end else begin
      if (idle_cnt != '1) idle_cnt <= idle_cnt + IDLE_CNT_W'(1);
      if (timeout_hit) begin
        stuck_q       <= 1'b1;
        stuck_level_q <= s;
      end
    end
  end

  // Published results; publish samples the counts before this cycle's reload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      high_len_q   <= '0;
      low_len_q    <= '0;
      period_q     <= '0;
      meas_sat_q   <= 1'b0;
      meas_valid_q <= 1'b0;
    end else begin
      meas_valid_q <= publish;
      if (publish) begin
        high_len_q <= hcnt;
        low_len_q  <= lcnt;
        period_q   <= {1'b0, hcnt} + {1'b0, lcnt};
        meas_sat_q <= hsat | lsat;
      end
    end
  end

  assign bus.high_len    = high_len_q;
  assign bus.low_len     = low_len_q;
  assign bus.period      = period_q;
  assign bus.meas_valid  = meas_valid_q;
  assign bus.meas_sat    = meas_sat_q;
  assign bus.stuck       = stuck_q;
  assign bus.stuck_level = stuck_level_q;
endmodule

// File: tb/tb_square_wave_meter.sv
// tb/tb_square_wave_meter.sv - directed self-checking bench for square_wave_meter
// Purpose: drives two meter instances (8-bit/TIMEOUT 200 and 4-bit/TIMEOUT 50)
//          with hand-built waveforms and compares against hand-computed results.
// Ports:   none (top-level bench)
module tb_square_wave_meter;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  square_wave_meter_if #(.CNT_W(8)) bus_a ();
  square_wave_meter_if #(.CNT_W(4)) bus_b ();

  square_wave_meter #(.CNT_W(8), .SYNC_STAGES(2), .TIMEOUT(200)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  square_wave_meter #(.CNT_W(4), .SYNC_STAGES(2), .TIMEOUT(50)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  typedef struct {
    int h;
    int l;
    int p;
    int sat;
  } meas_t;

  meas_t qa[$];
  meas_t qb[$];
  int    n_assert = 0;
  int    n_fail   = 0;

  always @(negedge clk) begin : mon_a
    meas_t m;
    if (bus_a.meas_valid) begin
      m.h   = int'(bus_a.high_len);
      m.l   = int'(bus_a.low_len);
      m.p   = int'(bus_a.period);
      m.sat = int'(bus_a.meas_sat);
      qa.push_back(m);
    end
  end

  always @(negedge clk) begin : mon_b
    meas_t m;
    if (bus_b.meas_valid) begin
      m.h   = int'(bus_b.high_len);
      m.l   = int'(bus_b.low_len);
      m.p   = int'(bus_b.period);
      m.sat = int'(bus_b.meas_sat);
      qb.push_back(m);
    end
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    n_assert++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_sig(input bit sel_b, input logic v);
    if (sel_b) bus_b.sig_in = v;
    else       bus_a.sig_in = v;
  endtask

  task automatic wave(input bit sel_b, input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      set_sig(sel_b, 1'b1);
      tick(hi);
      set_sig(sel_b, 1'b0);
      tick(lo);
    end
  endtask

  task automatic check_next(input bit sel_b, input string tag,
                            input int h, input int l, input int p, input int sat);
    meas_t m;
    int    sz;
    sz = sel_b ? qb.size() : qa.size();
    check_val({tag, "_avail"}, int'(sz > 0), 1);
    if (sz > 0) begin
      if (sel_b) m = qb.pop_front();
      else       m = qa.pop_front();
      check_val({tag, "_high"}, m.h, h);
      check_val({tag, "_low"}, m.l, l);
      check_val({tag, "_period"}, m.p, p);
      check_val({tag, "_sat"}, m.sat, sat);
    end
  endtask

  task automatic check_zero_a(input string tag);
    check_val({tag, "_high"}, int'(bus_a.high_len), 0);
    check_val({tag, "_low"}, int'(bus_a.low_len), 0);
    check_val({tag, "_period"}, int'(bus_a.period), 0);
    check_val({tag, "_valid"}, int'(bus_a.meas_valid), 0);
    check_val({tag, "_sat"}, int'(bus_a.meas_sat), 0);
    check_val({tag, "_stuck"}, int'(bus_a.stuck), 0);
    check_val({tag, "_stuck_lvl"}, int'(bus_a.stuck_level), 0);
  endtask

  initial begin
    rst          = 1'b1;
    bus_a.en     = 1'b1;
    bus_a.sig_in = 1'b1;
    bus_b.en     = 1'b1;
    bus_b.sig_in = 1'b0;
    tick(3);
    check_zero_a("reset");
    rst = 1'b0;

    // 1: 5 high / 3 low, then a timed rise to measure publish latency
    wave(1'b0, 5, 3, 4);
    bus_a.sig_in = 1'b1;
    tick(2);
    check_val("lat_early", int'(bus_a.meas_valid), 0);
    check_val("t1_count", qa.size(), 2);
    tick(1);
    check_val("lat_pulse", int'(bus_a.meas_valid), 1);
    check_val("lat_high", int'(bus_a.high_len), 5);
    check_val("lat_low", int'(bus_a.low_len), 3);
    check_val("lat_period", int'(bus_a.period), 8);
    tick(1);
    check_val("pulse_1cyc", int'(bus_a.meas_valid), 0);
    for (int i = 0; i < 3; i++) check_next(1'b0, "t1", 5, 3, 8, 0);

    // 2: switch to 2 high / 6 low; the current high stretches to 6 cycles
    wave(1'b0, 2, 6, 4);
    check_val("t2_count", qa.size(), 3);
    check_next(1'b0, "t2_mixed", 6, 6, 12, 0);
    check_next(1'b0, "t2_a", 2, 6, 8, 0);
    check_next(1'b0, "t2_b", 2, 6, 8, 0);

    // 6: minimum 1 high / 1 low
    wave(1'b0, 1, 1, 6);
    tick(4);
    check_val("t6_count", qa.size(), 6);
    check_next(1'b0, "t6_first", 2, 6, 8, 0);
    for (int i = 0; i < 5; i++) check_next(1'b0, "t6_min", 1, 1, 2, 0);

    // 5: enable dropped in HIGH for 10 cycles while the input keeps toggling
    bus_a.sig_in = 1'b1;
    tick(4);
    check_next(1'b0, "t5_pre", 1, 5, 6, 0);
    bus_a.en = 1'b0;
    bus_a.sig_in = 1'b1; tick(2);
    bus_a.sig_in = 1'b0; tick(3);
    bus_a.sig_in = 1'b1; tick(5);
    bus_a.en = 1'b1;
    check_val("en_no_valid", qa.size(), 0);
    check_val("en_hold_high", int'(bus_a.high_len), 1);
    check_val("en_hold_low", int'(bus_a.low_len), 5);
    check_val("en_hold_period", int'(bus_a.period), 6);
    wave(1'b0, 4, 4, 3);
    tick(2);
    check_val("en_resume_count", qa.size(), 1);
    check_next(1'b0, "en_resume", 4, 4, 8, 0);
    rst = 1'b1;
    #1;
    check_zero_a("rst_mid");
    tick(2);
    rst = 1'b0;

    // 3: CNT_W=4, 20 high / 3 low saturates the high counter
    wave(1'b1, 20, 3, 4);
    check_val("t3_count", qb.size(), 2);
    check_next(1'b1, "t3_a", 15, 3, 18, 1);
    check_next(1'b1, "t3_b", 15, 3, 18, 1);

    // 4: input held low; the last fall is processed 3 edges after the drive
    tick(49);
    check_val("stuck_early", int'(bus_b.stuck), 0);
    tick(1);
    check_val("stuck_set", int'(bus_b.stuck), 1);
    check_val("stuck_level", int'(bus_b.stuck_level), 0);
    bus_b.sig_in = 1'b1;
    tick(2);
    check_val("stuck_hold", int'(bus_b.stuck), 1);
    tick(1);
    check_val("stuck_clear", int'(bus_b.stuck), 0);
    bus_b.sig_in = 1'b0;
    tick(3);
    wave(1'b1, 3, 3, 1);
    check_val("t4_no_early", qb.size(), 0);
    wave(1'b1, 3, 3, 1);
    tick(4);
    check_val("t4_count", qb.size(), 1);
    check_next(1'b1, "t4", 3, 3, 6, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
